// File: rtl/wrr_arbiter.sv
// wrr_arbiter
//   Per-output packet arbiter for the crossbar. Chooses among N input ports
//   whose destination equals this output's index. A grant is held for whole
//   packets and for up to MAX_BURST consecutive packets from the same port.
//   After that, priority rotates to the port after the grantee.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   number     : index of the output served; static after reset
//   s_dest_i   : per-port destination field
//   s_valid_i  : per-port valid
//   s_last_i   : per-port last beat of packet
//   m_ready_i  : output-side ready
//   m_valid_o  : valid toward the output
//   m_last_o   : last toward the output
//   m_sel_o    : granted port index; drives the data mux
//   s_ready_o  : per-port ready, at most one bit high
//   busy_o     : arbiter holds a grant; this is also the visible FSM state
//
// Handshake: a beat transfers on a rising edge where m_valid_o and m_ready_i
// are both high. On the granted port this is the same as s_valid_i[g] and
// s_ready_o[g] being high. Valid never waits for ready. s_ready_o[g] follows
// m_ready_i combinationally while the grantee may start or continue a packet.
module wrr_arbiter #(
  parameter int N         = 4,
  parameter int DEST_W    = 2,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(N)   // derived; leave at default
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEST_W-1:0]      number,
  input  logic [N-1:0][DEST_W-1:0] s_dest_i,
  input  logic [N-1:0]           s_valid_i,
  input  logic [N-1:0]           s_last_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_last_o,
  output logic [ID_W-1:0]        m_sel_o,
  output logic [N-1:0]           s_ready_o,
  output logic                   busy_o
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      r_state;
  logic [ID_W-1:0] r_g;
  logic [ID_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic            r_mid;

  logic [N-1:0]    w_req;
  logic            w_any;
  logic [ID_W-1:0] w_pick;
  logic [ID_W-1:0] w_next_ptr;
  logic            w_locked;
  logic            w_ok;
  logic            w_fire;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < N; i++) begin
      w_req[i] = s_valid_i[i] && (s_dest_i[i] == number);
    end
  end

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_any && w_req[(int'(r_ptr) + k) % N]) begin
        w_any  = 1'b1;
        w_pick = ID_W'((int'(r_ptr) + k) % N);
      end
    end
  end

  assign w_next_ptr = (r_g == ID_W'(N - 1)) ? '0 : r_g + ID_W'(1);
  assign w_locked   = (r_state == ST_LOCKED);

  // The destination is checked only at packet start. Once inside a packet,
  // a changed destination must not stall the rest of the packet.
  assign w_ok = r_mid || (s_dest_i[r_g] == number);

  assign m_valid_o = w_locked && s_valid_i[r_g] && w_ok;
  assign m_last_o  = m_valid_o && s_last_i[r_g];
  assign m_sel_o   = r_g;
  assign busy_o    = w_locked;
  assign w_fire    = m_valid_o && m_ready_i;

  always_comb begin
    s_ready_o = '0;
    if (w_locked) begin
      s_ready_o[r_g] = m_ready_i && w_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_mid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_g     <= w_pick;
            r_state <= ST_LOCKED;
            r_cnt   <= '0;
            r_mid   <= 1'b0;
          end
        end
        default: begin
          if (w_fire) begin
            if (!s_last_i[r_g]) begin
              r_mid <= 1'b1;
            end else begin
              r_mid <= 1'b0;
              if (r_cnt == CNT_LAST) begin
                r_state <= ST_IDLE;
                r_ptr   <= w_next_ptr;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end else if (!r_mid && !w_req[r_g]) begin
            // Between packets with nothing more from the grantee:
            // give the other ports a turn.
            r_state <= ST_IDLE;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter
//   Directed bench for wrr_arbiter with N=4, DEST_W=2, MAX_BURST=2.
//   Expected beats are {sel, last, idle cycles before the beat}, all written
//   by hand. A monitor compares them against every transfer the DUT makes.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int DW = 2;
  localparam int MB = 2;
  localparam logic [4:0] GAP_X = 5'h1f;  // idle count not checked

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DW-1:0]        number;
  logic [N-1:0][DW-1:0] s_dest_i;
  logic [N-1:0]         s_valid_i;
  logic [N-1:0]         s_last_i;
  logic                 m_ready_i;
  logic                 m_valid_o;
  logic                 m_last_o;
  logic [1:0]           m_sel_o;
  logic [N-1:0]         s_ready_o;
  logic                 busy_o;

  wrr_arbiter #(.N(N), .DEST_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .number    (number),
    .s_dest_i  (s_dest_i),
    .s_valid_i (s_valid_i),
    .s_last_i  (s_last_i),
    .m_ready_i (m_ready_i),
    .m_valid_o (m_valid_o),
    .m_last_o  (m_last_o),
    .m_sel_o   (m_sel_o),
    .s_ready_o (s_ready_o),
    .busy_o    (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- source model state ----------------
  int          beats_left[N];
  int          pkts_left[N];
  int          pkt_len[N];
  logic [DW-1:0] dst[N];
  logic        gap[N];
  logic        fired[N];
  int          fires;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  int         idle_run;
  int         n_vec;
  int         n_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [1:0] sel, input logic last, input logic [4:0] g);
    exp_q.push_back({sel, last, g});
  endtask

  function automatic logic [8:0] outs();
    return {m_valid_o, m_last_o, s_ready_o, m_sel_o, busy_o};
  endfunction

  // Monitor: pops one expected beat for each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_unexpected: got sel %0d last %0d expected no beat at %0t",
                   m_sel_o, m_last_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_sel", 32'(m_sel_o), 32'(mon_e[7:6]));
          chk("beat_last", 32'(m_last_o), 32'(mon_e[5]));
          chk("beat_sready", 32'(s_ready_o), 32'(4'b0001 << mon_e[7:6]));
          if (mon_e[4:0] != GAP_X) chk("beat_gap", 32'(idle_run), 32'(mon_e[4:0]));
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid_i[i] = (beats_left[i] > 0) && !gap[i];
      s_last_i[i]  = (beats_left[i] == 1);
      s_dest_i[i]  = dst[i];
    end
  endtask

  task automatic load(input int i, input int npk, input int len, input logic [DW-1:0] d);
    beats_left[i] = len;
    pkts_left[i]  = npk - 1;
    pkt_len[i]    = len;
    dst[i]        = d;
    drive();
  endtask

  // Sample handshakes at negedge, then advance sources just after posedge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) fired[i] = s_valid_i[i] && s_ready_o[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        fires++;
        beats_left[i]--;
        if (beats_left[i] == 0 && pkts_left[i] > 0) begin
          pkts_left[i]--;
          beats_left[i] = pkt_len[i];
        end
      end
    end
    drive();
  endtask

  task automatic wait_fires(input int target, input int budget);
    int c = 0;
    while (fires < target && c < budget) begin
      tick();
      c++;
    end
    chk("wait_fires", 32'(fires >= target), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic [DW-1:0] num);
    rst       = 1'b1;
    m_ready_i = 1'b1;
    number    = num;
    for (int i = 0; i < N; i++) begin
      beats_left[i] = 0;
      pkts_left[i]  = 0;
      pkt_len[i]    = 0;
      gap[i]        = 1'b0;
      dst[i]        = '0;
    end
    drive();
    fires = 0;
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec    = 0;
    n_err    = 0;
    idle_run = 0;

    // Single port: port 1, 3 beats to dest 2.
    do_reset(2'd2);
    load(1, 1, 3, 2'd2);
    #1;
    chk("a_bubble_valid", 32'(m_valid_o), 32'd0);
    chk("a_bubble_busy", 32'(busy_o), 32'd0);
    push_beat(2'd1, 1'b0, GAP_X);
    push_beat(2'd1, 1'b0, 5'd0);
    push_beat(2'd1, 1'b1, 5'd0);
    tick();
    #1;
    chk("a_first_valid", 32'(m_valid_o), 32'd1);
    chk("a_first_sel", 32'(m_sel_o), 32'd1);
    chk("a_first_busy", 32'(busy_o), 32'd1);
    wait_drain(20);
    #1;
    chk("a_hold_after_last", 32'(busy_o), 32'd1);
    tick();
    #1;
    chk("a_idle_busy", 32'(busy_o), 32'd0);
    chk("a_idle_sel_holds", 32'(m_sel_o), 32'd1);
    // ptr is now 2: port 3 beats port 1.
    load(1, 1, 1, 2'd2);
    load(3, 1, 1, 2'd2);
    push_beat(2'd3, 1'b1, GAP_X);
    push_beat(2'd1, 1'b1, 5'd2);
    wait_drain(20);

    // Contention: ports 0 and 3, three 2-beat packets each, dest 0.
    do_reset(2'd0);
    load(0, 3, 2, 2'd0);
    load(3, 3, 2, 2'd0);
    push_beat(2'd0, 1'b0, GAP_X); push_beat(2'd0, 1'b1, 5'd0);
    push_beat(2'd0, 1'b0, 5'd0);  push_beat(2'd0, 1'b1, 5'd0);
    push_beat(2'd3, 1'b0, 5'd1);  push_beat(2'd3, 1'b1, 5'd0);
    push_beat(2'd3, 1'b0, 5'd0);  push_beat(2'd3, 1'b1, 5'd0);
    push_beat(2'd0, 1'b0, 5'd1);  push_beat(2'd0, 1'b1, 5'd0);
    push_beat(2'd3, 1'b0, 5'd2);  push_beat(2'd3, 1'b1, 5'd0);
    wait_drain(60);

    // Backpressure, source gap and mid-packet destination change.
    do_reset(2'd2);
    load(2, 1, 4, 2'd2);
    load(3, 1, 1, 2'd2);
    push_beat(2'd2, 1'b0, GAP_X);
    push_beat(2'd2, 1'b0, 5'd3);
    push_beat(2'd2, 1'b0, 5'd2);
    push_beat(2'd2, 1'b1, 5'd0);
    push_beat(2'd3, 1'b1, 5'd2);
    wait_fires(1, 10);
    m_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("c_stall_valid", 32'(m_valid_o), 32'd1);
      chk("c_stall_sready", 32'(s_ready_o), 32'd0);
      chk("c_stall_sel", 32'(m_sel_o), 32'd2);
      chk("c_stall_busy", 32'(busy_o), 32'd1);
      tick();
    end
    m_ready_i = 1'b1;
    wait_fires(2, 10);
    gap[2] = 1'b1;
    dst[2] = 2'd1;
    drive();
    for (int s = 0; s < 2; s++) begin
      #1;
      chk("c_gap_valid", 32'(m_valid_o), 32'd0);
      chk("c_gap_busy", 32'(busy_o), 32'd1);
      chk("c_gap_sel", 32'(m_sel_o), 32'd2);
      chk("c_gap_sready", 32'(s_ready_o), 32'b0100);
      tick();
    end
    gap[2] = 1'b0;
    drive();
    wait_drain(30);

    // Wrap to port 0 with port 3 idle; port 2 asks for another output.
    do_reset(2'd0);
    load(2, 1, 1, 2'd0);
    push_beat(2'd2, 1'b1, GAP_X);
    wait_fires(1, 10);
    load(2, 4, 1, 2'd1);
    load(0, 1, 2, 2'd0);
    push_beat(2'd0, 1'b0, 5'd2);
    push_beat(2'd0, 1'b1, 5'd0);
    wait_drain(20);
    tick();
    for (int s = 0; s < 6; s++) begin
      tick();
      #1;
      chk("d_mismatch_busy", 32'(busy_o), 32'd0);
      chk("d_mismatch_valid", 32'(m_valid_o), 32'd0);
    end
    load(3, 1, 1, 2'd0);
    push_beat(2'd3, 1'b1, GAP_X);
    wait_drain(20);

    // Reset mid-packet, then pointer must be back at 0.
    do_reset(2'd0);
    load(2, 1, 1, 2'd0);
    push_beat(2'd2, 1'b1, GAP_X);
    wait_drain(20);
    load(1, 1, 3, 2'd0);
    push_beat(2'd1, 1'b0, GAP_X);
    wait_fires(2, 20);
    #1;
    chk("e_beat2_presented", 32'(m_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("e_async_reset_outs", 32'(outs()), 32'd0);
    do_reset(2'd0);
    load(0, 1, 1, 2'd0);
    load(3, 1, 1, 2'd0);
    push_beat(2'd0, 1'b1, GAP_X);
    push_beat(2'd3, 1'b1, 5'd2);
    wait_drain(20);

    repeat (3) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
